// File: rtl/mem_stage_if.sv
// Bundle between the EX/MEM register, the data cache and the MEM/WB register.
// MemtoReg encoding: 0 = ALU, 1 = MEM, 2 = NPC.
interface mem_stage_if;
    logic [1:0]  MemtoReg;
    logic        RegWEN;
    logic        dRENi;
    logic        dWENi;
    logic        halt;
    logic [4:0]  rd;
    logic [31:0] ALUOut;
    logic [31:0] store;
    logic [31:0] npc;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        mm_stall;
    logic        wb_RegWEN;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdat;
    logic        wb_halt;
    logic        halted;

    // The memory stage itself consumes EX/MEM and cache responses.
    modport slave (
        input  MemtoReg, RegWEN, dRENi, dWENi, halt, rd, ALUOut, store, npc,
        input  dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mm_stall,
        output wb_RegWEN, wb_rd, wb_wdat, wb_halt, halted
    );

    modport master (
        output MemtoReg, RegWEN, dRENi, dWENi, halt, rd, ALUOut, store, npc,
        output dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mm_stall,
        input  wb_RegWEN, wb_rd, wb_wdat, wb_halt, halted
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-stage controller: issues a held dcache request for loads/stores,
// stalls upstream until dhit, fills MEM/WB and latches the processor halt.
module mem_stage (
    input logic       CLK,
    input logic       nRST,
    mem_stage_if.slave bus
);
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_NPC = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

    state_t      state;
    state_t      next_state;
    logic        access;
    logic        latch_req;
    logic        req_read;
    logic        req_write;
    logic        stall;
    logic        wb_load;
    logic        wb_regwen_next;
    logic        wb_halt_next;
    logic        halted_next;
    logic [31:0] sel_wdat;

    assign access = (bus.dRENi | bus.dWENi) & ~bus.halt;

    // Load data is only meaningful on the dhit cycle of BUSY; in IDLE MEM falls back to ALUOut.
    always_comb begin
        sel_wdat = bus.ALUOut;
        if (bus.MemtoReg == SEL_NPC)
            sel_wdat = bus.npc;
        else if (bus.MemtoReg == SEL_MEM && state == BUSY)
            sel_wdat = bus.dmemload;
    end

    always_comb begin
        next_state     = state;
        stall          = 1'b0;
        latch_req      = 1'b0;
        wb_load        = 1'b0;
        wb_regwen_next = 1'b0;
        wb_halt_next   = 1'b0;
        halted_next    = bus.halted;
        case (state)
            IDLE: begin
                if (access) begin
                    stall      = 1'b1;
                    latch_req  = 1'b1;
                    next_state = BUSY;
                end else if (bus.halt) begin
                    wb_halt_next = 1'b1;
                    halted_next  = 1'b1;
                    next_state   = HALTED;
                end else begin
                    wb_load        = 1'b1;
                    wb_regwen_next = bus.RegWEN;
                end
            end
            BUSY: begin
                if (bus.dhit) begin
                    wb_load        = 1'b1;
                    wb_regwen_next = bus.RegWEN;
                    next_state     = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            HALTED: begin
                stall        = 1'b1;
                wb_halt_next = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // A store wins over a simultaneous load request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.dmemaddr  <= '0;
            bus.dmemstore <= '0;
            req_read      <= 1'b0;
            req_write     <= 1'b0;
        end else if (latch_req) begin
            bus.dmemaddr  <= {bus.ALUOut[31:2], 2'b00};
            bus.dmemstore <= bus.store;
            req_read      <= bus.dRENi & ~bus.dWENi;
            req_write     <= bus.dWENi;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.wb_RegWEN <= 1'b0;
            bus.wb_rd     <= '0;
            bus.wb_wdat   <= '0;
            bus.wb_halt   <= 1'b0;
            bus.halted    <= 1'b0;
        end else begin
            bus.wb_RegWEN <= wb_regwen_next;
            bus.wb_halt   <= wb_halt_next;
            bus.halted    <= halted_next;
            if (wb_load) begin
                bus.wb_rd   <= bus.rd;
                bus.wb_wdat <= sel_wdat;
            end
        end
    end

    assign bus.dmemREN  = (state == BUSY) & req_read;
    assign bus.dmemWEN  = (state == BUSY) & req_write;
    assign bus.mm_stall = stall;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream checked against a transaction-level model.
module tb_mem_stage;
    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_NPC = 2'd2;

    // Instruction kinds used by the stimulus tasks.
    localparam int KIND_ALU   = 0;
    localparam int KIND_JAL   = 1;
    localparam int KIND_LOAD  = 2;
    localparam int KIND_STORE = 3;
    localparam int KIND_BOTH  = 4;

    logic CLK;
    logic nRST;
    int   checkCount;
    int   failCount;

    mem_stage_if bus ();

    mem_stage dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One instruction through the stage; the model derives everything from the kind and fields.
    task automatic applyStimulus(input int kind, input int waits, input logic [31:0] alu,
                                 input logic [31:0] st, input logic [31:0] np,
                                 input logic [31:0] load, input logic [4:0] r, input logic wen);
        logic        isMem;
        logic        expRen;
        logic        expWen;
        logic [1:0]  sel;
        logic [31:0] expWdat;
        isMem  = (kind >= KIND_LOAD);
        expRen = (kind == KIND_LOAD);
        expWen = (kind == KIND_STORE) || (kind == KIND_BOTH);
        sel    = (kind == KIND_JAL) ? SEL_NPC : (kind == KIND_LOAD) ? SEL_MEM : SEL_ALU;
        if (sel == SEL_MEM)      expWdat = load;
        else if (sel == SEL_NPC) expWdat = np;
        else                     expWdat = alu;

        bus.MemtoReg = sel;
        bus.RegWEN   = wen;
        bus.dRENi    = (kind == KIND_LOAD) || (kind == KIND_BOTH);
        bus.dWENi    = expWen;
        bus.halt     = 1'b0;
        bus.rd       = r;
        bus.ALUOut   = alu;
        bus.store    = st;
        bus.npc      = np;
        bus.dhit     = isMem ? 1'b0 : 1'($urandom_range(0, 1));
        bus.dmemload = $urandom;
        #1;
        checkOutput("stall_first", 32'(bus.mm_stall), 32'(isMem));
        checkOutput("ren_idle", 32'(bus.dmemREN), 32'd0);
        checkOutput("wen_idle", 32'(bus.dmemWEN), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        if (isMem) begin
            for (int c = 0; c <= waits; c++) begin
                bus.dhit = (c == waits);
                bus.dmemload = (c == waits) ? load : $urandom;
                #1;
                checkOutput("busy_ren", 32'(bus.dmemREN), 32'(expRen));
                checkOutput("busy_wen", 32'(bus.dmemWEN), 32'(expWen));
                checkOutput("busy_addr", bus.dmemaddr, {alu[31:2], 2'b00});
                checkOutput("busy_store", bus.dmemstore, st);
                checkOutput("busy_stall", 32'(bus.mm_stall), 32'(c != waits));
                checkOutput("busy_bubble", 32'(bus.wb_RegWEN), 32'd0);
                @(posedge CLK);
                @(negedge CLK);
            end
            bus.dhit = 1'b0;
        end
        checkOutput("wb_regwen", 32'(bus.wb_RegWEN), 32'(wen));
        checkOutput("wb_rd", 32'(bus.wb_rd), 32'(r));
        checkOutput("wb_wdat", bus.wb_wdat, expWdat);
        checkOutput("wb_halt", 32'(bus.wb_halt), 32'd0);
        checkOutput("halted", 32'(bus.halted), 32'd0);
    endtask

    initial begin
        checkCount   = 0;
        failCount    = 0;
        nRST         = 1'b0;
        bus.MemtoReg = SEL_ALU;
        bus.RegWEN   = 1'b0;
        bus.dRENi    = 1'b1;
        bus.dWENi    = 1'b0;
        bus.halt     = 1'b0;
        bus.rd       = '0;
        bus.ALUOut   = '0;
        bus.store    = '0;
        bus.npc      = '0;
        bus.dhit     = 1'b0;
        bus.dmemload = '0;

        // Reset values with a load pending at the input.
        @(negedge CLK);
        #1;
        checkOutput("rst_ren", 32'(bus.dmemREN), 32'd0);
        checkOutput("rst_wen", 32'(bus.dmemWEN), 32'd0);
        checkOutput("rst_addr", bus.dmemaddr, 32'd0);
        checkOutput("rst_store", bus.dmemstore, 32'd0);
        checkOutput("rst_wbregwen", 32'(bus.wb_RegWEN), 32'd0);
        checkOutput("rst_wbrd", 32'(bus.wb_rd), 32'd0);
        checkOutput("rst_wbwdat", bus.wb_wdat, 32'd0);
        checkOutput("rst_wbhalt", 32'(bus.wb_halt), 32'd0);
        checkOutput("rst_halted", 32'(bus.halted), 32'd0);
        checkOutput("rst_stall", 32'(bus.mm_stall), 32'd1);
        bus.dRENi  = 1'b0;
        bus.RegWEN = 1'b1;
        bus.rd     = 5'd5;
        bus.ALUOut = 32'h10;
        nRST       = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("post_rst_rd", 32'(bus.wb_rd), 32'd5);
        checkOutput("post_rst_wdat", bus.wb_wdat, 32'h10);
        checkOutput("post_rst_stall", 32'(bus.mm_stall), 32'd0);

        applyStimulus(KIND_LOAD, 3, 32'h0000_0103, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd9, 1'b1);
        applyStimulus(KIND_BOTH, 0, 32'h0000_0200, 32'h1234_5678, 32'h0, 32'h0, 5'd3, 1'b0);
        applyStimulus(KIND_JAL, 0, 32'h0000_0777, 32'h0, 32'h44, 32'h0, 5'd31, 1'b1);

        for (int i = 0; i < 150; i++)
            applyStimulus($urandom_range(0, 4), $urandom_range(0, 4), $urandom, $urandom,
                          $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

        // Reset pulsed in the middle of a load.
        bus.MemtoReg = SEL_MEM;
        bus.RegWEN   = 1'b1;
        bus.dRENi    = 1'b1;
        bus.dWENi    = 1'b0;
        bus.rd       = 5'd12;
        bus.ALUOut   = 32'h0000_0300;
        bus.dhit     = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("abort_ren_before", 32'(bus.dmemREN), 32'd1);
        nRST = 1'b0;
        #1;
        checkOutput("abort_ren_after", 32'(bus.dmemREN), 32'd0);
        checkOutput("abort_addr", bus.dmemaddr, 32'd0);
        checkOutput("abort_wbregwen", 32'(bus.wb_RegWEN), 32'd0);
        bus.dRENi    = 1'b0;
        bus.MemtoReg = SEL_ALU;
        bus.rd       = 5'd7;
        bus.ALUOut   = 32'h55;
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h0000_0BAD;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("abort_next_wdat", bus.wb_wdat, 32'h55);
        checkOutput("abort_next_rd", 32'(bus.wb_rd), 32'd7);
        checkOutput("abort_next_ren", 32'(bus.dmemREN), 32'd0);
        checkOutput("abort_next_stall", 32'(bus.mm_stall), 32'd0);

        // Load followed directly by a halt, then a load that must never issue.
        applyStimulus(KIND_LOAD, 2, 32'h0000_0040, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd4, 1'b1);
        bus.halt  = 1'b1;
        bus.dRENi = 1'b1;
        #1;
        checkOutput("halt_stall", 32'(bus.mm_stall), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("halt_wbhalt", 32'(bus.wb_halt), 32'd1);
        checkOutput("halt_halted", 32'(bus.halted), 32'd1);
        checkOutput("halt_wbregwen", 32'(bus.wb_RegWEN), 32'd0);
        bus.halt = 1'b0;
        bus.dhit = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("halted_ren", 32'(bus.dmemREN), 32'd0);
            checkOutput("halted_stall", 32'(bus.mm_stall), 32'd1);
            checkOutput("halted_sticky", 32'(bus.halted), 32'd1);
            checkOutput("halted_wbhalt", 32'(bus.wb_halt), 32'd1);
            @(posedge CLK);
            @(negedge CLK);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-stage controller on the consumer end of the EX/MEM pipeline register. Takes the latched EX/MEM fields and turns load/store requests into a registered dcache request that is held until `dhit`. Stalls the upstream pipeline while the access is outstanding. Writes the resolved result into the MEM/WB register and latches the processor halt.

## Interface
- No parameters. Widths come from `cpu_types_pkg`: `word_t` = 32, `regbits_t` = 5. `memtoreg_t` comes from `control_unit_types_pkg` with encodings ALU, MEM, NPC.
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- MemtoReg  in  memtoreg_t  writeback source select, from EX/MEM.
- RegWEN  in  1  register-file write enable, from EX/MEM.
- dRENi  in  1  load request, from EX/MEM.
- dWENi  in  1  store request, from EX/MEM.
- halt  in  1  halt instruction present in EX/MEM.
- rd  in  5  destination register.
- ALUOut  in  32  effective address or ALU result.
- store  in  32  store data.
- npc  in  32  PC+4, used for link writes.
- dhit  in  1  dcache access complete.
- dmemload  in  32  load data; valid when `dhit`=1.
- dmemREN  out  1  dcache read request.
- dmemWEN  out  1  dcache write request.
- dmemaddr  out  32  request address.
- dmemstore  out  32  request store data.
- mm_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- wb_RegWEN  out  1  MEM/WB register-write enable.
- wb_rd  out  5  MEM/WB destination register.
- wb_wdat  out  32  MEM/WB writeback data.
- wb_halt  out  1  MEM/WB halt flag.
- halted  out  1  sticky halt indication to the system.

## Operation
- `access` = (`dRENi` | `dWENi`) & !`halt`. If both `dRENi` and `dWENi` are set, `dWENi` wins and the read is dropped.
- FSM states are IDLE, BUSY and HALTED.
- IDLE with `access`=1:
  - `mm_stall`=1.
  - Latch request registers: `dmemaddr` ← {`ALUOut`[31:2], 2'b00}, `dmemstore` ← `store`, and the read/write type.
  - Go to BUSY.
  - MEM/WB receives a bubble: `wb_RegWEN`=0, `wb_halt`=0.
- IDLE with `access`=0 and `halt`=0:
  - `mm_stall`=0.
  - MEM/WB ← {`RegWEN`, `rd`, sel}, where sel = `ALUOut` for ALU or MEM, and `npc` for NPC.
- IDLE with `halt`=1:
  - `mm_stall`=0.
  - MEM/WB ← {RegWEN=0, wb_halt=1}. `halted` ← 1. Go to HALTED.
- BUSY:
  - `dmemREN`/`dmemWEN` are driven from the latched type. Address and data are stable for every cycle of BUSY.
  - When `dhit`=0: `mm_stall`=1, MEM/WB ← bubble.
  - When `dhit`=1: `mm_stall`=0, go to IDLE, and MEM/WB ← {`RegWEN`, `rd`, wdat}.
  - wdat = `dmemload` for MEM, `ALUOut` for ALU, `npc` for NPC. A store normally has `RegWEN`=0, and that value is passed as given.
- HALTED:
  - No dcache requests are issued. `mm_stall`=1. MEM/WB holds a bubble with `wb_halt`=1.
  - `halted` stays 1. Only reset leaves this state.
- Outside BUSY, `dmemREN`=`dmemWEN`=0. `dmemaddr`/`dmemstore` hold their last latched value.
- `opfunc` and `equal` from EX/MEM are not used by this block.

## Timing
- Reset: asynchronous, effective immediately.
  - State → IDLE.
  - Outputs: `dmemREN`=0, `dmemWEN`=0, `dmemaddr`=0, `dmemstore`=0, `wb_RegWEN`=0, `wb_rd`=0, `wb_wdat`=0, `wb_halt`=0, `halted`=0.
  - `mm_stall` follows the IDLE equation, so it is 0 unless the input `access` is set.
- Reset while BUSY drops the request in the same cycle. No MEM/WB update is produced for the aborted access.
- Non-memory instruction: 1 cycle through the stage, no stall.
- Memory instruction:
  - Minimum occupancy is 2 cycles: latch cycle plus a BUSY cycle with `dhit`=1.
  - Each additional cycle with `dhit`=0 adds 1 stall cycle.
  - MEM/WB is valid the cycle after the `dhit` edge.
- `mm_stall` is combinational from state, inputs and `dhit`. It must deassert in the same cycle `dhit` is sampled high.
- EX/MEM inputs are held by upstream while `mm_stall`=1. The block does not re-sample them in BUSY.
- `dhit` while IDLE or HALTED is ignored.
- Back-to-back memory instructions: the next latch happens in the first IDLE cycle after the previous `dhit`. There is no idle gap beyond the latch cycle.

## Test plan
- Reset: hold nRST=0 with `dRENi`=1 at the input → all outputs 0 except `mm_stall`=1. Release with `RegWEN`=1, `rd`=5, `ALUOut`=0x10, MemtoReg=ALU → next edge gives `wb_rd`=5, `wb_wdat`=0x10, `mm_stall`=0.
- Load, `ALUOut`=0x0000_0103, `dhit` low for 3 BUSY cycles then high with `dmemload`=0xDEADBEEF:
  - `dmemaddr`=0x100 and `dmemREN`=1 for 4 cycles.
  - `mm_stall`=1 for 4 cycles.
  - MEM/WB gets `wb_wdat`=0xDEADBEEF.
- Store with `dRENi`=`dWENi`=1, `store`=0x12345678, immediate `dhit` → `dmemWEN`=1, `dmemREN`=0, `dmemstore`=0x12345678, 2-cycle occupancy.
- JAL pass-through: MemtoReg=NPC, `npc`=0x44, `rd`=31 → `wb_wdat`=0x44, `wb_rd`=31, no stall.
- Halt arriving while a prior load is BUSY:
  - The load completes first.
  - The next cycle sets `wb_halt`=1 and `halted`=1.
  - A later `dRENi` produces no `dmemREN`.
- nRST pulsed low mid-BUSY → `dmemREN` drops immediately, state is IDLE, and no writeback of the aborted load occurs.
